// File: rtl/rename_regfile_pkg.sv
// Shared widths, bus types and constants for the rename register file.
package rename_regfile_pkg;

    localparam int unsigned RegNum = 32;
    localparam int unsigned NameW  = 5;
    localparam int unsigned NickW  = 5;
    localparam int unsigned DataW  = 32;

    typedef logic [NameW-1:0] name_bus_t;
    typedef logic [NickW-1:0] nick_bus_t;
    typedef logic [DataW-1:0] data_bus_t;

    // Nick value meaning "no pending producer, data valid".
    localparam nick_bus_t ZeroNick = '0;

endpackage

// File: rtl/rename_regfile_read_port.sv
// One dispatch read port: x0 forcing and same-cycle commit bypass on top of
// the raw register/tag values selected by the parent.
module rename_regfile_read_port
    import rename_regfile_pkg::*;
#(
    parameter int unsigned NAME_W = NameW,
    parameter int unsigned NICK_W = NickW,
    parameter int unsigned DATA_W = DataW
) (
    input  logic [NAME_W-1:0] rs,
    input  logic [DATA_W-1:0] reg_dt,
    input  logic [NICK_W-1:0] reg_nick,
    input  logic              byp_en,
    input  logic [NAME_W-1:0] byp_regnm,
    input  logic [DATA_W-1:0] byp_dt,
    input  logic [NICK_W-1:0] byp_nick,
    output logic [DATA_W-1:0] dt,
    output logic [NICK_W-1:0] nick
);

    logic rs_is_zero;
    logic byp_hit;

    assign rs_is_zero = (rs == '0);
    assign byp_hit    = byp_en && (byp_regnm == rs) && !rs_is_zero && (reg_nick == byp_nick);

    // Select x0 constant, committing value, or stored state.
    always_comb begin
        dt   = reg_dt;
        nick = reg_nick;
        if (rs_is_zero) begin
            dt   = '0;
            nick = '0;
        end else if (byp_hit) begin
            dt   = byp_dt;
            nick = '0;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register producer nick table.
// Fed by ROB commit and nick-allocation broadcast; read by dispatch.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int unsigned REG_NUM = RegNum,
    parameter int unsigned NAME_W  = NameW,
    parameter int unsigned NICK_W  = NickW,
    parameter int unsigned DATA_W  = DataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iROB_nick_en,
    input  logic [NICK_W-1:0] iROB_nick,
    input  logic [NAME_W-1:0] iROB_nick_regnm,
    input  logic              iROB_en,
    input  logic [NAME_W-1:0] iROB_rd_regnm,
    input  logic [DATA_W-1:0] iROB_rd_dt,
    input  logic [NICK_W-1:0] iROB_rd_nick,
    input  logic [NAME_W-1:0] iDP_rs1_regnm,
    input  logic [NAME_W-1:0] iDP_rs2_regnm,
    output logic [DATA_W-1:0] oDP_rs1_dt,
    output logic [NICK_W-1:0] oDP_rs1_nick,
    output logic [DATA_W-1:0] oDP_rs2_dt,
    output logic [NICK_W-1:0] oDP_rs2_nick
);

    logic [DATA_W-1:0] dt_q   [REG_NUM];
    logic [NICK_W-1:0] nick_q [REG_NUM];

    logic commit_wr;
    logic rename_wr;
    logic byp_en;

    assign commit_wr = iROB_en && (iROB_rd_regnm != '0);
    assign rename_wr = iROB_nick_en && (iROB_nick_regnm != '0);
    assign byp_en    = rdy && iROB_en;

    // Commit writes data and retires a matching tag; flush/rename then
    // override the tag (later non-blocking assignment wins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dt_q   <= '{default: '0};
            nick_q <= '{default: '0};
        end else if (rdy) begin
            if (commit_wr) begin
                dt_q[iROB_rd_regnm] <= iROB_rd_dt;
                if (nick_q[iROB_rd_regnm] == iROB_rd_nick) begin
                    nick_q[iROB_rd_regnm] <= '0;
                end
            end
            if (iclr) begin
                nick_q <= '{default: '0};
            end else if (rename_wr) begin
                nick_q[iROB_nick_regnm] <= iROB_nick;
            end
        end
    end

    rename_regfile_read_port #(
        .NAME_W (NAME_W),
        .NICK_W (NICK_W),
        .DATA_W (DATA_W)
    ) u_rs1 (
        .rs        (iDP_rs1_regnm),
        .reg_dt    (dt_q[iDP_rs1_regnm]),
        .reg_nick  (nick_q[iDP_rs1_regnm]),
        .byp_en    (byp_en),
        .byp_regnm (iROB_rd_regnm),
        .byp_dt    (iROB_rd_dt),
        .byp_nick  (iROB_rd_nick),
        .dt        (oDP_rs1_dt),
        .nick      (oDP_rs1_nick)
    );

    rename_regfile_read_port #(
        .NAME_W (NAME_W),
        .NICK_W (NICK_W),
        .DATA_W (DATA_W)
    ) u_rs2 (
        .rs        (iDP_rs2_regnm),
        .reg_dt    (dt_q[iDP_rs2_regnm]),
        .reg_nick  (nick_q[iDP_rs2_regnm]),
        .byp_en    (byp_en),
        .byp_regnm (iROB_rd_regnm),
        .byp_dt    (iROB_rd_dt),
        .byp_nick  (iROB_rd_nick),
        .dt        (oDP_rs2_dt),
        .nick      (oDP_rs2_nick)
    );

    // A rename must never allocate the reserved "ready" nick.
    a_nick_nonzero: assert property (@(posedge clk) disable iff (!rst)
        (rdy && iROB_nick_en) |-> (iROB_nick != '0));

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: directed cases plus random traffic
// against an array-based reference model.
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        iclr = 1'b0;
    logic        iROB_nick_en = 1'b0;
    logic [4:0]  iROB_nick = 5'd0;
    logic [4:0]  iROB_nick_regnm = 5'd0;
    logic        iROB_en = 1'b0;
    logic [4:0]  iROB_rd_regnm = 5'd0;
    logic [31:0] iROB_rd_dt = 32'd0;
    logic [4:0]  iROB_rd_nick = 5'd0;
    logic [4:0]  iDP_rs1_regnm = 5'd0;
    logic [4:0]  iDP_rs2_regnm = 5'd0;
    logic [31:0] oDP_rs1_dt;
    logic [4:0]  oDP_rs1_nick;
    logic [31:0] oDP_rs2_dt;
    logic [4:0]  oDP_rs2_nick;

    always #5 clk = ~clk;

    rename_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .iclr            (iclr),
        .iROB_nick_en    (iROB_nick_en),
        .iROB_nick       (iROB_nick),
        .iROB_nick_regnm (iROB_nick_regnm),
        .iROB_en         (iROB_en),
        .iROB_rd_regnm   (iROB_rd_regnm),
        .iROB_rd_dt      (iROB_rd_dt),
        .iROB_rd_nick    (iROB_rd_nick),
        .iDP_rs1_regnm   (iDP_rs1_regnm),
        .iDP_rs2_regnm   (iDP_rs2_regnm),
        .oDP_rs1_dt      (oDP_rs1_dt),
        .oDP_rs1_nick    (oDP_rs1_nick),
        .oDP_rs2_dt      (oDP_rs2_dt),
        .oDP_rs2_nick    (oDP_rs2_nick)
    );

    typedef struct {
        string       tag;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] dt1;
        logic [4:0]  nk1;
        logic [31:0] dt2;
        logic [4:0]  nk2;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_dt   [32];
    logic [4:0]  m_nick [32];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_dt[i]   = 32'd0;
            m_nick[i] = 5'd0;
        end
    endfunction

    // Architectural view a dispatcher sees this cycle.
    function automatic void model_read(input logic [4:0] rs, output logic [31:0] d, output logic [4:0] n);
        if (rs == 5'd0) begin
            d = 32'd0;
            n = 5'd0;
        end else if (rdy && iROB_en && iROB_rd_regnm == rs && m_nick[rs] == iROB_rd_nick) begin
            d = iROB_rd_dt;
            n = 5'd0;
        end else begin
            d = m_dt[rs];
            n = m_nick[rs];
        end
    endfunction

    // State after the coming clock edge.
    function automatic void model_update();
        logic [4:0] nn [32];
        if (!(rst && rdy)) return;
        nn = m_nick;
        if (iROB_en && iROB_rd_regnm != 5'd0) begin
            m_dt[iROB_rd_regnm] = iROB_rd_dt;
            if (m_nick[iROB_rd_regnm] == iROB_rd_nick) nn[iROB_rd_regnm] = 5'd0;
        end
        if (iclr) begin
            for (int i = 0; i < 32; i++) nn[i] = 5'd0;
        end else if (iROB_nick_en && iROB_nick_regnm != 5'd0) begin
            nn[iROB_nick_regnm] = iROB_nick;
        end
        m_nick = nn;
    endfunction

    function automatic void push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.rs1 = iDP_rs1_regnm;
        e.rs2 = iDP_rs2_regnm;
        model_read(iDP_rs1_regnm, e.dt1, e.nk1);
        model_read(iDP_rs2_regnm, e.dt2, e.nk2);
        sb.push_back(e);
    endfunction

    task automatic step(input string tag, input logic r, input logic c,
                        input logic ne, input logic [4:0] nk, input logic [4:0] nreg,
                        input logic ce, input logic [4:0] creg, input logic [31:0] cdt,
                        input logic [4:0] cnk, input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        rdy             = r;
        iclr            = c;
        iROB_nick_en    = ne;
        iROB_nick       = nk;
        iROB_nick_regnm = nreg;
        iROB_en         = ce;
        iROB_rd_regnm   = creg;
        iROB_rd_dt      = cdt;
        iROB_rd_nick    = cnk;
        iDP_rs1_regnm   = r1;
        iDP_rs2_regnm   = r2;
        push_exp(tag);
        model_update();
    endtask

    task automatic rd(input string tag, input logic [4:0] r1, input logic [4:0] r2);
        step(tag, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, r1, r2);
    endtask

    task automatic ren(input string tag, input logic [4:0] reg_n, input logic [4:0] nk);
        step(tag, 1'b1, 1'b0, 1'b1, nk, reg_n, 1'b0, 5'd0, 32'd0, 5'd0, reg_n, 5'd0);
    endtask

    // Drop reset between clock edges and expect cleared reads before the next edge.
    task automatic mid_reset(input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        rdy = 1'b1; iclr = 1'b0; iROB_nick_en = 1'b0; iROB_en = 1'b0;
        iDP_rs1_regnm = r1;
        iDP_rs2_regnm = r2;
        #2;
        rst = 1'b0;
        model_clear();
        push_exp("async_reset");
    endtask

    // Monitor: compare DUT read outputs with the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (oDP_rs1_dt !== e.dt1) begin
                miscompares++;
                $display("FAIL %s rs1_dt x%0d: got %h expected %h", e.tag, e.rs1, oDP_rs1_dt, e.dt1);
            end
            if (oDP_rs1_nick !== e.nk1) begin
                miscompares++;
                $display("FAIL %s rs1_nick x%0d: got %0d expected %0d", e.tag, e.rs1, oDP_rs1_nick, e.nk1);
            end
            if (oDP_rs2_dt !== e.dt2) begin
                miscompares++;
                $display("FAIL %s rs2_dt x%0d: got %h expected %h", e.tag, e.rs2, oDP_rs2_dt, e.dt2);
            end
            if (oDP_rs2_nick !== e.nk2) begin
                miscompares++;
                $display("FAIL %s rs2_nick x%0d: got %0d expected %0d", e.tag, e.rs2, oDP_rs2_nick, e.nk2);
            end
        end
    end

    initial begin
        logic        r, c, ne, ce;
        logic [4:0]  nk, nreg, creg, cnk, r1, r2;
        logic [31:0] cdt;

        model_clear();
        iDP_rs1_regnm = 5'd5;
        iDP_rs2_regnm = 5'd0;
        push_exp("reset_state");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rdy = 1'b1;

        // Rename then commit with same-cycle bypass.
        ren("ren_x5", 5'd5, 5'd3);
        rd("x5_pending", 5'd5, 5'd0);
        step("commit_x5_bypass", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd3, 5'd5, 5'd5);
        rd("x5_retired", 5'd5, 5'd0);

        // Older producer commits while a younger one owns the register.
        ren("ren_x7_a", 5'd7, 5'd4);
        ren("ren_x7_b", 5'd7, 5'd9);
        step("commit_x7_stale", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11, 5'd4, 5'd7, 5'd0);
        rd("x7_young_owner", 5'd7, 5'd7);

        // Rename and commit of the same register in one cycle.
        ren("ren_x8", 5'd8, 5'd6);
        step("ren_commit_x8", 1'b1, 1'b0, 1'b1, 5'd12, 5'd8, 1'b1, 5'd8, 32'h22, 5'd6, 5'd8, 5'd0);
        rd("x8_after", 5'd8, 5'd0);

        // Flush with concurrent commit and dropped rename.
        ren("ren_x1", 5'd1, 5'd1);
        ren("ren_x2", 5'd2, 5'd2);
        ren("ren_x3", 5'd3, 5'd3);
        step("flush", 1'b1, 1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 5'd4, 32'h44, 5'd5, 5'd1, 5'd4);
        rd("post_flush_a", 5'd1, 5'd2);
        rd("post_flush_b", 5'd3, 5'd4);
        rd("post_flush_c", 5'd6, 5'd8);

        // rdy low: no update and no bypass.
        step("stall", 1'b0, 1'b0, 1'b1, 5'd10, 5'd9, 1'b1, 5'd8, 32'h55, 5'd0, 5'd8, 5'd9);
        rd("post_stall", 5'd8, 5'd9);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            r    = ($urandom_range(9, 0) != 0);
            c    = ($urandom_range(19, 0) == 0);
            ne   = 1'($urandom_range(1, 0));
            nk   = 5'($urandom_range(31, 1));
            nreg = 5'($urandom_range(31, 0));
            ce   = 1'($urandom_range(1, 0));
            creg = 5'($urandom_range(31, 0));
            cnk  = (m_nick[creg] != 5'd0 && $urandom_range(3, 0) != 0) ? m_nick[creg] : 5'($urandom_range(31, 1));
            cdt  = $urandom;
            r1   = ($urandom_range(1, 0) != 0) ? creg : 5'($urandom_range(31, 0));
            r2   = 5'($urandom_range(31, 0));
            step("random", r, c, ne, nk, nreg, ce, creg, cdt, cnk, r1, r2);
        end

        // x0 is hardwired.
        step("x0_write", 1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 1'b1, 5'd0, 32'h99, 5'd7, 5'd0, 5'd0);
        rd("x0_read", 5'd0, 5'd0);

        // Make sure there is live state, then reset asynchronously.
        step("preset_x5", 1'b1, 1'b0, 1'b1, 5'd21, 5'd9, 1'b1, 5'd5, 32'hCAFE0005, 5'd31, 5'd5, 5'd9);
        mid_reset(5'd5, 5'd9);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd("after_reset_a", 5'd5, 5'd9);
        rd("after_reset_b", 5'd8, 5'd4);

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
